// File: rtl/ir_nec_rx.sv
// NEC infrared frame decoder: times mark/space phases in 1 us ticks, shifts in
// the 32-bit payload and strobes command, repeat or error results.
module ir_nec_rx #(
  parameter int TICK_DIV    = 50,
  parameter int TIMEOUT_US  = 12000,
  parameter int REPEAT_FLAG = 0
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       ir_in,
  output logic       flag,
  output logic [7:0] correspond,
  output logic [7:0] addr,
  output logic       rpt,
  output logic       err
);

  localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [15:0]     TIMEOUT  = 16'(TIMEOUT_US);
  localparam logic            RPT_FLAG = (REPEAT_FLAG != 0);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_L,
    LEAD_H,
    BIT_L,
    BIT_H,
    STOP_L,
    RPT_L
  } state_t;

  logic             r_ir_m;
  logic             r_ir_s;
  logic             r_ir_d;
  logic [PRE_W-1:0] r_pre;
  logic [15:0]      r_us_cnt;
  state_t           r_state;
  logic [31:0]      r_sr;
  logic [5:0]       r_bit_cnt;
  logic             r_have_valid;
  logic             r_flag;
  logic             r_rpt;
  logic             r_err;
  logic [7:0]       r_cmd;
  logic [7:0]       r_addr;

  logic             w_edge;
  logic             w_rise;
  logic             w_fall;
  logic             w_tick;
  logic             w_win_lead;
  logic             w_win_space;
  logic             w_win_rpt;
  logic             w_win_short;
  logic             w_win_one;
  logic             w_frame_ok;
  state_t           w_state_nxt;
  logic [31:0]      w_sr_nxt;
  logic [5:0]       w_cnt_nxt;
  logic             w_flag_nxt;
  logic             w_rpt_nxt;
  logic             w_err_nxt;
  logic             w_load;

  function automatic logic in_win(input logic [15:0] len,
                                  input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (len >= lo) && (len <= hi);
  endfunction

  // ir_in is asynchronous; the synchronizer is deliberately left out of reset so
  // that a clr while the line is low cannot fabricate an edge afterwards.
  always_ff @(posedge clock) begin
    r_ir_m <= ir_in;
    r_ir_s <= r_ir_m;
    r_ir_d <= r_ir_s;
  end

  assign w_edge = r_ir_s ^ r_ir_d;
  assign w_rise = w_edge & r_ir_s;
  assign w_fall = w_edge & ~r_ir_s;
  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clock) begin
    if (clr) begin
      r_pre    <= '0;
      r_us_cnt <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_edge) begin
        r_us_cnt <= '0;
      end else if (w_tick && (r_us_cnt != 16'hFFFF)) begin
        r_us_cnt <= r_us_cnt + 16'd1;
      end
    end
  end

  assign w_win_lead  = in_win(r_us_cnt, 16'd8000, 16'd10000);
  assign w_win_space = in_win(r_us_cnt, 16'd4000, 16'd5000);
  assign w_win_rpt   = in_win(r_us_cnt, 16'd2000, 16'd2500);
  assign w_win_short = in_win(r_us_cnt, 16'd400,  16'd700);
  assign w_win_one   = in_win(r_us_cnt, 16'd1400, 16'd1900);
  assign w_frame_ok  = (r_sr[15:8] == ~r_sr[7:0]) && (r_sr[31:24] == ~r_sr[23:16]);

  // Phase length is only judged on the edge that ends it; between edges the
  // only way out of a frame is the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_bit_cnt;
    w_flag_nxt  = 1'b0;
    w_rpt_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    if (w_edge) begin
      case (r_state)
        IDLE: begin
          if (w_fall) w_state_nxt = LEAD_L;
        end
        LEAD_L: begin
          if (w_rise && w_win_lead) w_state_nxt = LEAD_H;
          else                      w_err_nxt   = 1'b1;
        end
        LEAD_H: begin
          if (w_fall && w_win_space) begin
            w_state_nxt = BIT_L;
            w_cnt_nxt   = 6'd0;
          end else if (w_fall && w_win_rpt) begin
            w_state_nxt = RPT_L;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        BIT_L: begin
          if (w_rise && w_win_short) w_state_nxt = BIT_H;
          else                       w_err_nxt   = 1'b1;
        end
        BIT_H: begin
          if (w_fall && (w_win_short || w_win_one)) begin
            w_sr_nxt    = {w_win_one, r_sr[31:1]};
            w_cnt_nxt   = r_bit_cnt + 6'd1;
            w_state_nxt = (w_cnt_nxt == 6'd32) ? STOP_L : BIT_L;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        STOP_L: begin
          if (w_rise && w_win_short) begin
            w_state_nxt = IDLE;
            if (w_frame_ok) begin
              w_flag_nxt = 1'b1;
              w_load     = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        RPT_L: begin
          if (w_rise && w_win_short) begin
            w_state_nxt = IDLE;
            if (r_have_valid) begin
              w_rpt_nxt  = 1'b1;
              w_flag_nxt = RPT_FLAG;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if ((r_state != IDLE) && (r_us_cnt >= TIMEOUT)) begin
      w_err_nxt = 1'b1;
    end
    if (w_err_nxt) w_state_nxt = IDLE;
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      r_state      <= IDLE;
      r_sr         <= '0;
      r_bit_cnt    <= '0;
      r_have_valid <= 1'b0;
      r_flag       <= 1'b0;
      r_rpt        <= 1'b0;
      r_err        <= 1'b0;
      r_cmd        <= '0;
      r_addr       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_flag    <= w_flag_nxt;
      r_rpt     <= w_rpt_nxt;
      r_err     <= w_err_nxt;
      if (w_load) begin
        r_cmd        <= r_sr[23:16];
        r_addr       <= r_sr[7:0];
        r_have_valid <= 1'b1;
      end
    end
  end

  assign flag       = r_flag;
  assign rpt        = r_rpt;
  assign err        = r_err;
  assign correspond = r_cmd;
  assign addr       = r_addr;

endmodule

// File: tb/tb_ir_nec_rx.sv
// Self-checking bench for ir_nec_rx: two instances (repeat flagging off/on)
// share one IR line driven with randomized NEC timing.
module tb_ir_nec_rx;

  localparam int TD = 2;

  logic       clock = 1'b0;
  logic       clr   = 1'b1;
  logic       ir_in = 1'b1;
  logic       flag0, rpt0, err0, flag1, rpt1, err1;
  logic [7:0] corr0, addr0, corr1, addr1;

  int cyc = 0;
  int nf0 = 0, nr0 = 0, ne0 = 0, nf1 = 0, nr1 = 0, ne1 = 0;
  int f0_cyc = 0, e0_cyc = 0, f1_cyc = 0, r1_cyc = 0;
  int rise_cyc = 0, fall_cyc = 0;
  int n_checks = 0, n_fail = 0;

  logic       m_have = 1'b0;
  logic [7:0] m_cmd  = 8'h00;
  logic [7:0] m_addr = 8'h00;

  ir_nec_rx #(.TICK_DIV(TD), .TIMEOUT_US(12000), .REPEAT_FLAG(0)) dut0 (
    .clock(clock), .clr(clr), .ir_in(ir_in), .flag(flag0),
    .correspond(corr0), .addr(addr0), .rpt(rpt0), .err(err0));

  ir_nec_rx #(.TICK_DIV(TD), .TIMEOUT_US(12000), .REPEAT_FLAG(1)) dut1 (
    .clock(clock), .clr(clr), .ir_in(ir_in), .flag(flag1),
    .correspond(corr1), .addr(addr1), .rpt(rpt1), .err(err1));

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse counters and timestamps, sampled shortly after each rising edge.
  always @(posedge clock) begin
    #2;
    if (flag0) begin nf0 <= nf0 + 1; f0_cyc <= cyc; end
    if (rpt0)  nr0 <= nr0 + 1;
    if (err0)  begin ne0 <= ne0 + 1; e0_cyc <= cyc; end
    if (flag1) begin nf1 <= nf1 + 1; f1_cyc <= cyc; end
    if (rpt1)  begin nr1 <= nr1 + 1; r1_cyc <= cyc; end
    if (err1)  ne1 <= ne1 + 1;
  end

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi - 5, lo + 5));
  endfunction

  function automatic logic frame_ok(input logic [31:0] w);
    return (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
  endfunction

  function automatic logic [31:0] make_word(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic hold(input logic lvl, input int us);
    if (lvl && !ir_in) rise_cyc = cyc;
    if (!lvl && ir_in) fall_cyc = cyc;
    ir_in = lvl;
    repeat (us * TD) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    hold(1'b0, rnd(400, 700));
    hold(1'b1, b ? rnd(1400, 1900) : rnd(400, 700));
  endtask

  task automatic send_frame(input logic [31:0] w);
    hold(1'b0, rnd(8000, 10000));
    hold(1'b1, rnd(4000, 5000));
    for (int i = 0; i < 32; i++) send_bit(w[i]);
    hold(1'b0, rnd(400, 700));
    hold(1'b1, 200);
  endtask

  task automatic send_repeat();
    hold(1'b0, rnd(8000, 10000));
    hold(1'b1, rnd(2000, 2500));
    hold(1'b0, rnd(400, 700));
    hold(1'b1, 200);
  endtask

  task automatic model_frame(input logic [31:0] w);
    if (frame_ok(w)) begin
      m_cmd  = w[23:16];
      m_addr = w[7:0];
      m_have = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_cmd  = 8'h00;
    m_addr = 8'h00;
    m_have = 1'b0;
  endtask

  task automatic test_reset();
    clr   = 1'b1;
    ir_in = 1'b1;
    repeat (6) @(negedge clock);
    clr = 1'b0;
    model_reset();
    n_checks++;
    if ({flag0, rpt0, err0, flag1, rpt1, err1} !== 6'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 000000", {flag0, rpt0, err0, flag1, rpt1, err1});
    end
    n_checks++;
    if ({corr0, addr0, corr1, addr1} !== {m_cmd, m_addr, m_cmd, m_addr}) begin
      n_fail++; $display("FAIL reset_bytes: got %h expected %h", {corr0, addr0, corr1, addr1}, {m_cmd, m_addr, m_cmd, m_addr});
    end
    hold(1'b1, 100);
  endtask

  task automatic test_valid();
    int bf0, bf1, be0, br0;
    logic [31:0] w;
    bf0 = nf0; bf1 = nf1; be0 = ne0; br0 = nr0;
    w = make_word(8'h00, 8'h0F);
    model_frame(w);
    send_frame(w);
    n_checks++;
    if (nf0 - bf0 !== 1) begin n_fail++; $display("FAIL valid_flag0_count: got %0d expected 1", nf0 - bf0); end
    n_checks++;
    if (nf1 - bf1 !== 1) begin n_fail++; $display("FAIL valid_flag1_count: got %0d expected 1", nf1 - bf1); end
    n_checks++;
    if ((ne0 - be0) + (nr0 - br0) !== 0) begin
      n_fail++; $display("FAIL valid_no_err_rpt: got %0d expected 0", (ne0 - be0) + (nr0 - br0));
    end
    n_checks++;
    if (f0_cyc - rise_cyc !== 3) begin n_fail++; $display("FAIL valid_latency: got %0d expected 3", f0_cyc - rise_cyc); end
    n_checks++;
    if ({corr0, addr0} !== {m_cmd, m_addr}) begin
      n_fail++; $display("FAIL valid_bytes: got %h expected %h", {corr0, addr0}, {m_cmd, m_addr});
    end
  endtask

  task automatic test_bad_inverse();
    int bf0, be0, be1;
    logic [31:0] w;
    bf0 = nf0; be0 = ne0; be1 = ne1;
    w = {8'hF1, 8'h0F, 8'hFF, 8'h00};
    model_frame(w);
    send_frame(w);
    n_checks++;
    if (ne0 - be0 !== 1 || ne1 - be1 !== 1) begin
      n_fail++; $display("FAIL badinv_err_count: got %0d/%0d expected 1/1", ne0 - be0, ne1 - be1);
    end
    n_checks++;
    if (nf0 - bf0 !== 0) begin n_fail++; $display("FAIL badinv_no_flag: got %0d expected 0", nf0 - bf0); end
    n_checks++;
    if (corr0 !== m_cmd) begin n_fail++; $display("FAIL badinv_held_cmd: got %h expected %h", corr0, m_cmd); end
  endtask

  task automatic test_repeat();
    int bf0, bf1, br0, br1, be0;
    bf0 = nf0; bf1 = nf1; br0 = nr0; br1 = nr1; be0 = ne0;
    send_repeat();
    n_checks++;
    if (nr0 - br0 !== int'(m_have) || nf0 - bf0 !== 0) begin
      n_fail++; $display("FAIL repeat_dut0: got rpt=%0d flag=%0d expected rpt=%0d flag=0", nr0 - br0, nf0 - bf0, m_have);
    end
    n_checks++;
    if (ne0 - be0 !== int'(!m_have)) begin n_fail++; $display("FAIL repeat_err: got %0d expected %0d", ne0 - be0, !m_have); end
    n_checks++;
    if (nr1 - br1 !== 1 || nf1 - bf1 !== 1 || r1_cyc !== f1_cyc) begin
      n_fail++; $display("FAIL repeat_dut1: got rpt=%0d flag=%0d cyc %0d/%0d expected 1 1 same", nr1 - br1, nf1 - bf1, r1_cyc, f1_cyc);
    end
    n_checks++;
    if (corr1 !== m_cmd) begin n_fail++; $display("FAIL repeat_cmd1: got %h expected %h", corr1, m_cmd); end
  endtask

  task automatic test_repeat_after_reset();
    int bf0, br0, be0, be1, bf1;
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    model_reset();
    hold(1'b1, 50);
    bf0 = nf0; br0 = nr0; be0 = ne0; be1 = ne1; bf1 = nf1;
    send_repeat();
    n_checks++;
    if (ne0 - be0 !== 1 || ne1 - be1 !== 1) begin
      n_fail++; $display("FAIL rst_repeat_err: got %0d/%0d expected 1/1", ne0 - be0, ne1 - be1);
    end
    n_checks++;
    if ((nr0 - br0) + (nf0 - bf0) + (nf1 - bf1) !== 0) begin
      n_fail++; $display("FAIL rst_repeat_quiet: got %0d expected 0", (nr0 - br0) + (nf0 - bf0) + (nf1 - bf1));
    end
  endtask

  task automatic test_bit_error();
    int bf0, be0;
    logic [31:0] w;
    w = $urandom;
    bf0 = nf0; be0 = ne0;
    hold(1'b0, rnd(8000, 10000));
    hold(1'b1, rnd(4000, 5000));
    for (int i = 0; i < 5; i++) send_bit(w[i]);
    hold(1'b0, rnd(400, 700));
    hold(1'b1, 1000);
    hold(1'b0, rnd(400, 700));
    n_checks++;
    if (ne0 - be0 !== 1) begin n_fail++; $display("FAIL biterr_count: got %0d expected 1", ne0 - be0); end
    n_checks++;
    if (e0_cyc - fall_cyc !== 3) begin n_fail++; $display("FAIL biterr_latency: got %0d expected 3", e0_cyc - fall_cyc); end
    hold(1'b1, 300);
    n_checks++;
    if (ne0 - be0 !== 1 || nf0 - bf0 !== 0) begin
      n_fail++; $display("FAIL biterr_idle: got err=%0d flag=%0d expected 1 0", ne0 - be0, nf0 - bf0);
    end
    w = make_word(8'($urandom), 8'h03);
    bf0 = nf0;
    model_frame(w);
    send_frame(w);
    n_checks++;
    if (nf0 - bf0 !== 1 || {corr0, addr0} !== {m_cmd, m_addr}) begin
      n_fail++; $display("FAIL biterr_recover: got flag=%0d bytes=%h expected 1 %h", nf0 - bf0, {corr0, addr0}, {m_cmd, m_addr});
    end
  endtask

  task automatic test_timeout();
    int bf0, be0, br0, dt;
    bf0 = nf0; be0 = ne0;
    hold(1'b0, 15000);
    dt = e0_cyc - fall_cyc;
    n_checks++;
    if (ne0 - be0 !== 1 || nf0 - bf0 !== 0) begin
      n_fail++; $display("FAIL timeout_pulses: got err=%0d flag=%0d expected 1 0", ne0 - be0, nf0 - bf0);
    end
    n_checks++;
    if (dt < 12000 * TD || dt > 12000 * TD + 8) begin
      n_fail++; $display("FAIL timeout_time: got %0d cycles expected about %0d", dt, 12000 * TD);
    end
    hold(1'b1, 300);
    n_checks++;
    if (ne0 - be0 !== 1) begin n_fail++; $display("FAIL timeout_rise_ignored: got %0d expected 1", ne0 - be0); end
    br0 = nr0;
    send_repeat();
    n_checks++;
    if (nr0 - br0 !== int'(m_have)) begin n_fail++; $display("FAIL timeout_then_repeat: got %0d expected %0d", nr0 - br0, m_have); end
  endtask

  task automatic test_clr_mid();
    int bf0, be0, br0;
    logic [31:0] w;
    w = $urandom;
    bf0 = nf0; be0 = ne0; br0 = nr0;
    hold(1'b0, rnd(8000, 10000));
    hold(1'b1, rnd(4000, 5000));
    for (int i = 0; i < 10; i++) send_bit(w[i]);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    model_reset();
    n_checks++;
    if ({corr0, addr0, corr1, addr1, flag0, rpt0, err0} !== {m_cmd, m_addr, m_cmd, m_addr, 3'b000}) begin
      n_fail++; $display("FAIL clr_outputs: got %h expected %h", {corr0, addr0, corr1, addr1, flag0, rpt0, err0},
                         {m_cmd, m_addr, m_cmd, m_addr, 3'b000});
    end
    hold(1'b1, 300);
    n_checks++;
    if ((nf0 - bf0) + (ne0 - be0) + (nr0 - br0) !== 0) begin
      n_fail++; $display("FAIL clr_no_pulses: got %0d expected 0", (nf0 - bf0) + (ne0 - be0) + (nr0 - br0));
    end
    w = make_word(8'($urandom), 8'h04);
    bf0 = nf0;
    model_frame(w);
    send_frame(w);
    n_checks++;
    if (nf0 - bf0 !== 1 || {corr0, addr0} !== {m_cmd, m_addr}) begin
      n_fail++; $display("FAIL clr_recover: got flag=%0d bytes=%h expected 1 %h", nf0 - bf0, {corr0, addr0}, {m_cmd, m_addr});
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_valid();
    test_bad_inverse();
    test_repeat();
    test_repeat_after_reset();
    test_bit_error();
    test_timeout();
    test_clr_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
